// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single external memory port between instruction fetch
// (read-only) and the data cache (read/write). One transaction at a time; the data side has
// fixed priority, but fetch is forced to win after STARVE_MAX consecutive data grants taken
// while fetch was waiting.
//
// Optional build macro: ARB_PERF_CNT_EN adds grant and wait performance counters.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req_i/if_addr_i          fetch read request (held until if_gnt_o)
//   if_gnt_o/if_rvalid_o        one-cycle grant / read-data-valid pulses for fetch
//   if_rdata_o                  fetch read data (holds last value)
//   dm_req_i/dm_we_i/dm_be_i    data request, write enable, byte enables
//   dm_addr_i/dm_wdata_i        data address / write data (held until dm_gnt_o)
//   dm_gnt_o/dm_rvalid_o        one-cycle grant / read-data-valid pulses for data
//   dm_rdata_o                  data read data (holds last value)
//   bus_req_o..bus_wdata_o      registered transaction toward memory
//   bus_ready_i                 memory accepts bus_req_o this cycle
//   bus_rvalid_i/bus_rdata_i    memory read response
//   if_grant_cnt_o, dm_grant_cnt_o, wait_cnt_o   (ARB_PERF_CNT_EN only) wrapping counters
module mem_port_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [3:0]      dm_be_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [3:0]      bus_be_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_ready_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]     if_grant_cnt_o,
    output logic [31:0]     dm_grant_cnt_o,
    output logic [31:0]     wait_cnt_o
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    localparam logic [3:0] StarveMaxC = 4'(STARVE_MAX);

    state_e          state_q;
    logic            owner_dm_q;  // 0 = fetch owns the port, 1 = data cache
    logic [3:0]      starve_cnt_q;
    logic            if_gnt_q, dm_gnt_q, if_rvalid_q, dm_rvalid_q;
    logic [XLEN-1:0] if_rdata_q, dm_rdata_q;
    logic            bus_req_q, bus_we_q;
    logic [3:0]      bus_be_q;
    logic [XLEN-1:0] bus_addr_q, bus_wdata_q;
    logic            pick_dm;

    // Data wins unless fetch is also waiting and has already been passed over STARVE_MAX times.
    assign pick_dm = dm_req_i && !(if_req_i && (starve_cnt_q == StarveMaxC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_dm_q   <= 1'b0;
            starve_cnt_q <= '0;
            if_gnt_q     <= 1'b0;
            dm_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            dm_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_req_i || dm_req_i) begin
                        bus_req_q <= 1'b1;
                        state_q   <= StIssue;
                        if (pick_dm) begin
                            owner_dm_q  <= 1'b1;
                            dm_gnt_q    <= 1'b1;
                            bus_we_q    <= dm_we_i;
                            bus_be_q    <= dm_be_i;
                            bus_addr_q  <= dm_addr_i;
                            bus_wdata_q <= dm_wdata_i;
                            if (if_req_i && (starve_cnt_q != StarveMaxC)) begin
                                starve_cnt_q <= starve_cnt_q + 4'd1;
                            end
                        end else begin
                            owner_dm_q   <= 1'b0;
                            if_gnt_q     <= 1'b1;
                            bus_we_q     <= 1'b0;
                            bus_be_q     <= 4'hF;
                            bus_addr_q   <= if_addr_i;
                            bus_wdata_q  <= '0;
                            starve_cnt_q <= '0;
                        end
                    end
                end
                StIssue: begin
                    if (bus_ready_i) begin
                        bus_req_q <= 1'b0;
                        // Writes get no response, so they return straight to arbitration.
                        state_q   <= bus_we_q ? StIdle : StResp;
                    end
                end
                StResp: begin
                    if (bus_rvalid_i) begin
                        if (owner_dm_q) begin
                            dm_rdata_q  <= bus_rdata_i;
                            dm_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= bus_rdata_i;
                            if_rvalid_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign dm_gnt_o    = dm_gnt_q;
    assign if_rvalid_o = if_rvalid_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_be_o    = bus_be_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_grant_cnt_q, dm_grant_cnt_q, wait_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_grant_cnt_q <= '0;
            dm_grant_cnt_q <= '0;
            wait_cnt_q     <= '0;
        end else begin
            if (if_gnt_q) if_grant_cnt_q <= if_grant_cnt_q + 32'd1;
            if (dm_gnt_q) dm_grant_cnt_q <= dm_grant_cnt_q + 32'd1;
            // A cycle counts as waiting when someone requests and no grant is being pulsed.
            if ((if_req_i || dm_req_i) && !(if_gnt_q || dm_gnt_q)) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
        end
    end

    assign if_grant_cnt_o = if_grant_cnt_q;
    assign dm_grant_cnt_o = dm_grant_cnt_q;
    assign wait_cnt_o     = wait_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_grant_cnt, dm_grant_cnt, wait_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_be_i     (dm_be),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_gnt_o    (dm_gnt),
        .dm_rvalid_o (dm_rvalid),
        .dm_rdata_o  (dm_rdata),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_be_o    (bus_be),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_ready_i (bus_ready),
        .bus_rvalid_i(bus_rvalid),
        .bus_rdata_i (bus_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .if_grant_cnt_o(if_grant_cnt),
        .dm_grant_cnt_o(dm_grant_cnt),
        .wait_cnt_o    (wait_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Fetch read with an immediately responding memory; must be called in an IDLE cycle.
    task automatic fetch_txn(input string tag, input logic [31:0] addr, input logic [31:0] data);
        if_req     = 1'b1;
        if_addr    = addr;
        bus_ready  = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = data;
        cyc();  // cycle 1
        chk({tag, "_gnt"}, if_gnt, 1'b1);
        chk({tag, "_bus_req"}, bus_req, 1'b1);
        chk({tag, "_bus_addr"}, bus_addr, addr);
        chk({tag, "_bus_be"}, bus_be, 4'hF);
        chk({tag, "_bus_we"}, bus_we, 1'b0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
        if_req = 1'b0;
        cyc();  // cycle 2
        chk({tag, "_c2_rvalid"}, if_rvalid, 1'b0);
        chk({tag, "_c2_gnt"}, if_gnt, 1'b0);
        cyc();  // cycle 3
        chk({tag, "_rvalid"}, if_rvalid, 1'b1);
        chk({tag, "_rdata"}, if_rdata, data);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
    endtask

`ifdef ARB_PERF_CNT_EN
    // Both requesters at once: data write wins, fetch follows after one IDLE cycle.
    task automatic both_round(input logic [31:0] data);
        if_req     = 1'b1;
        if_addr    = 32'h400;
        dm_req     = 1'b1;
        dm_we      = 1'b1;
        dm_addr    = 32'h500;
        bus_ready  = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = data;
        cyc();  // cycle 1
        chk("rnd_dm_gnt", dm_gnt, 1'b1);
        dm_req = 1'b0;
        cyc();  // cycle 2
        chk("rnd_if_nogt", if_gnt, 1'b0);
        cyc();  // cycle 3
        chk("rnd_if_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        cyc();
        cyc();  // cycle 5
        chk("rnd_if_rdata", if_rdata, data);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        dm_we      = 1'b0;
    endtask
`endif

    logic exp_dm [8];

    initial begin
        int n;
        exp_dm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_dm_gnt", dm_gnt, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_bus_be", bus_be, 4'h0);
        rst_n = 1'b1;
        cyc();

        // Single fetch read at minimum latency
        fetch_txn("fetch1", 32'h100, 32'h0050_0093);
        cyc();
        chk("fetch1_rvalid_pulse", if_rvalid, 1'b0);
        chk("fetch1_rdata_hold", if_rdata, 32'h0050_0093);

        // Data write, bus_ready delayed, fields stable; no response
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        cyc();  // cycle 1
        chk("wr_gnt", dm_gnt, 1'b1);
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'hFFFF_0000; dm_wdata = 32'h0; dm_be = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            chk("wr_bus_req", bus_req, 1'b1);
            chk("wr_bus_we", bus_we, 1'b1);
            chk("wr_bus_addr", bus_addr, 32'h2000);
            chk("wr_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
            chk("wr_bus_be", bus_be, 4'b0011);
            if (k == 5) bus_ready = 1'b1;
            cyc();
        end
        chk("wr_bus_req_drop", bus_req, 1'b0);
        chk("wr_no_rvalid", dm_rvalid, 1'b0);
        // A request driven now being granted next cycle shows the FSM is already in IDLE.
        fetch_txn("fetch2", 32'h104, 32'h1111_1111);
        chk("wr_no_rvalid_late", dm_rvalid, 1'b0);

        // Starvation guard: both held high, expect D D D I D D D I
        cyc();
        if_req = 1'b1; if_addr = 32'h108; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
        n = 0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            cyc();
            if (if_gnt || dm_gnt) begin
                chk($sformatf("starve_grant%0d", n), {31'b0, dm_gnt}, {31'b0, exp_dm[n]});
                chk("starve_excl", {31'b0, if_gnt & dm_gnt}, 32'h0);
                n++;
                if (n == 8) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        chk("starve_grant_count", n, 8);
        if_req = 1'b0; dm_req = 1'b0;
        repeat (4) cyc();
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        cyc();

        // Data read: spurious rvalid in ISSUE, real rvalid 5 cycles into RESP
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
        cyc();  // cycle 1
        chk("rd_gnt", dm_gnt, 1'b1);
        dm_req = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        cyc();  // cycle 2
        chk("rd_spur_rvalid", dm_rvalid, 1'b0);
        bus_rvalid = 1'b0; bus_ready = 1'b1;
        cyc();  // cycle 3, RESP
        bus_ready = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            chk("rd_wait_rvalid", dm_rvalid, 1'b0);
            cyc();
        end
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;  // cycle 8
        cyc();
        chk("rd_rvalid", dm_rvalid, 1'b1);
        chk("rd_rdata", dm_rdata, 32'hCAFE_F00D);
        bus_rvalid = 1'b0;
        cyc();
        chk("rd_rvalid_once", dm_rvalid, 1'b0);

        // Reset while in RESP
        if_req = 1'b1; if_addr = 32'h200; bus_ready = 1'b1;
        cyc();
        if_req = 1'b0;
        cyc();  // RESP
        rst_n = 1'b0;
        #1;
        chk("mrst_bus_req", bus_req, 1'b0);
        chk("mrst_if_rdata", if_rdata, 32'h0);
        chk("mrst_dm_rdata", dm_rdata, 32'h0);
        chk("mrst_bus_addr", bus_addr, 32'h0);
        chk("mrst_bus_be", bus_be, 4'h0);
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        cyc();
        rst_n = 1'b1;
        repeat (3) begin
            cyc();
            chk("mrst_no_if_rvalid", if_rvalid, 1'b0);
            chk("mrst_no_bus_req", bus_req, 1'b0);
        end
        bus_rvalid = 1'b0;
        fetch_txn("fetch3", 32'h300, 32'h1234_5678);

`ifdef ARB_PERF_CNT_EN
        // Perf counters: 5 paired rounds (2 wait cycles each) + 5 lone fetches (1 each)
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("perf_rst_wait", wait_cnt, 32'h0);
        chk("perf_rst_if", if_grant_cnt, 32'h0);
        for (int r = 0; r < 5; r++) both_round(32'hA000_0000 + r);
        for (int r = 0; r < 5; r++) fetch_txn("perf_fetch", 32'h600 + 4 * r, 32'hB000_0000 + r);
        cyc();
        chk("perf_if_grants", if_grant_cnt, 32'd10);
        chk("perf_dm_grants", dm_grant_cnt, 32'd5);
        chk("perf_wait", wait_cnt, 32'd15);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
